emu_soc_top: RTL and testbench



---
 rtl/emu_soc_top.sv | 221 ++++++++++++++++++++++
 tb/tb_emu_soc_top.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/emu_soc_top.sv
// == emu_soc_top: single-cycle RV32I-subset CPU with unified word memory ==
// == rev 1.0 -- all architectural state is plain flops/memory words     ==
`default_nettype none

module emu_soc_top #(
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_rdata;
  logic [31:0] dmem_wdata;
  logic        dmem_wen;

  emu_soc_cpu #(.RESET_PC(RESET_PC)) u_cpu (
    .clock      (clock),
    .reset      (reset),
    .inst       (inst),
    .imem_addr  (imem_addr),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .dmem_wen   (dmem_wen),
    .dmem_wdata (dmem_wdata),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  emu_soc_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clock (clock),
    .iaddr (imem_addr),
    .inst  (inst),
    .daddr (dmem_addr),
    .rdata (dmem_rdata),
    .wen   (dmem_wen),
    .wdata (dmem_wdata)
  );
endmodule

module emu_soc_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst,
  output logic [31:0] imem_addr,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_wen,
  output logic [31:0] dmem_wdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0]       pc;
  logic [31:0][31:0] rf;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, pc_plus4;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign rs1v     = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2v     = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign pc_plus4 = pc + 32'd4;

  logic [31:0] alu_b, alu_out;
  logic        alu_alt, alu_legal;
  logic        br_taken, br_legal;

  // Shared ALU for OP-IMM and OP; alt selects SUB / SRA.
  always_comb begin
    alu_b     = (opcode == OP_REG) ? rs2v : imm_i;
    alu_alt   = 1'b0;
    alu_legal = 1'b0;
    if (opcode == OP_REG) begin
      alu_alt   = funct7[5];
      alu_legal = (funct7 == 7'h00) ||
                  (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
    end else begin
      alu_alt = (funct3 == 3'b101) && funct7[5];
      case (funct3)
        3'b001:  alu_legal = (funct7 == 7'h00);
        3'b101:  alu_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        default: alu_legal = 1'b1;
      endcase
    end
    case (funct3)
      3'b000:  alu_out = alu_alt ? (rs1v - alu_b) : (rs1v + alu_b);
      3'b001:  alu_out = rs1v << alu_b[4:0];
      3'b010:  alu_out = {31'd0, $signed(rs1v) < $signed(alu_b)};
      3'b011:  alu_out = {31'd0, rs1v < alu_b};
      3'b100:  alu_out = rs1v ^ alu_b;
      3'b101:  alu_out = alu_alt ? 32'($signed(rs1v) >>> alu_b[4:0]) : (rs1v >> alu_b[4:0]);
      3'b110:  alu_out = rs1v | alu_b;
      default: alu_out = rs1v & alu_b;
    endcase
  end

  always_comb begin
    br_legal = 1'b1;
    case (funct3)
      3'b000:  br_taken = (rs1v == rs2v);
      3'b001:  br_taken = (rs1v != rs2v);
      3'b100:  br_taken = ($signed(rs1v) < $signed(rs2v));
      3'b101:  br_taken = ($signed(rs1v) >= $signed(rs2v));
      3'b110:  br_taken = (rs1v < rs2v);
      3'b111:  br_taken = (rs1v >= rs2v);
      default: begin br_taken = 1'b0; br_legal = 1'b0; end
    endcase
  end

  logic [31:0] next_pc, result, addr_imm;
  logic        wr, mem_we;

  // Anything not matched below leaves the defaults: pc+4, no writes.
  always_comb begin
    next_pc  = pc_plus4;
    result   = 32'd0;
    wr       = 1'b0;
    mem_we   = 1'b0;
    addr_imm = imm_i;
    case (opcode)
      OP_LUI:   begin wr = 1'b1; result = imm_u; end
      OP_AUIPC: begin wr = 1'b1; result = pc + imm_u; end
      OP_JAL:   begin wr = 1'b1; result = pc_plus4; next_pc = pc + imm_j; end
      OP_JALR: if (funct3 == 3'b000) begin
        wr      = 1'b1;
        result  = pc_plus4;
        next_pc = (rs1v + imm_i) & ~32'd1;
      end
      OP_BRANCH: if (br_legal && br_taken) next_pc = pc + imm_b;
      OP_LOAD: if (funct3 == 3'b010) begin wr = 1'b1; result = dmem_rdata; end
      OP_STORE: if (funct3 == 3'b010) begin mem_we = 1'b1; addr_imm = imm_s; end
      OP_IMM, OP_REG: if (alu_legal) begin wr = 1'b1; result = alu_out; end
      default: ;
    endcase
  end

  assign rf_wen     = wr && (rd != 5'd0) && !reset;
  assign rf_waddr   = rf_wen ? rd : 5'd0;
  assign rf_wdata   = rf_wen ? result : 32'd0;
  assign dmem_wen   = mem_we && !reset;
  assign dmem_addr  = rs1v + addr_imm;
  assign dmem_wdata = rs2v;
  assign imem_addr  = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      rf <= '0;
    end else begin
      pc <= next_pc;
      if (rf_wen) rf[rd] <= result;
    end
  end
endmodule

module emu_soc_mem #(
  parameter int MEM_WORDS = 65536
) (
  input  logic        clock,
  input  logic [31:0] iaddr,
  output logic [31:0] inst,
  input  logic [31:0] daddr,
  output logic [31:0] rdata,
  input  logic        wen,
  input  logic [31:0] wdata
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [0:MEM_WORDS-1];
  logic [AW-1:0] iidx, didx;

  // Upper address bits are dropped so out-of-range addresses alias.
  assign iidx  = iaddr[AW+1:2];
  assign didx  = daddr[AW+1:2];
  assign inst  = mem[iidx];
  assign rdata = mem[didx];

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2], daddr[1:0]};

  always_ff @(posedge clock) begin
    if (wen) mem[didx] <= wdata;
  end
endmodule

`default_nettype wire

// File: tb/tb_emu_soc_top.sv
// == tb_emu_soc_top: directed checks of emu_soc_top incl. checkpoint/restore ==
// == rev 1.0                                                                ==
`default_nettype none

module tb_emu_soc_top;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks   = 0;
  int failures = 0;

  localparam int OPI = 7'b0010011;
  localparam int OPR = 7'b0110011;
  localparam int LD  = 7'b0000011;
  localparam int JLR = 7'b1100111;

  logic [37:0]       trace [0:511];
  logic [31:0]       saved_pc;
  logic [31:0][31:0] saved_rf;
  logic [31:0]       saved_mem [0:127];

  emu_soc_top dut (
    .clock    (clock),
    .reset    (reset),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, OPI);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".wen"},   {31'd0, rf_wen},  {31'd0, w});
    chk({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, a});
    chk({tag, ".wdata"}, rf_wdata, d);
  endtask

  task automatic tick;
    #5 clock = 1'b1;
    #5 clock = 1'b0;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 128; i++) dut.u_mem.mem[i] <= 32'd0;
  endtask

  task automatic put(input int idx, input logic [31:0] v);
    dut.u_mem.mem[idx] <= v;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
  endtask

  // Runs until word 3 leaves its sentinel; records or replays the output trace from cycle 200.
  task automatic run_to_finish(input int start, input bit replay, output int fin, output int mism);
    int cyc;
    cyc  = start;
    fin  = 0;
    mism = 0;
    for (int n = 0; n < 1000 && fin == 0; n++) begin
      if (cyc >= 200 && cyc < 512) begin
        if (replay) begin
          if ({rf_wen, rf_waddr, rf_wdata} !== trace[cyc]) mism++;
        end else begin
          trace[cyc] = {rf_wen, rf_waddr, rf_wdata};
        end
      end
      tick;
      cyc++;
      if (!replay && cyc == 200) begin
        saved_pc = dut.u_cpu.pc;
        saved_rf = dut.u_cpu.rf;
        for (int i = 0; i < 128; i++) saved_mem[i] = dut.u_mem.mem[i];
      end
      if (dut.u_mem.mem[3] !== 32'hFFFF_FFFF) fin = cyc;
    end
  endtask

  initial begin
    int fin1, fin2, mism;

    // Program 1: reset, ALU, memory, x0, NOP
    clear_mem;
    put(0,  addi(1, 0, 5));
    put(1,  enc_j(32'h3C, 0));
    put(3,  32'hFFFF_FFFF);
    put(16, addi(2, 0, -1));
    put(17, enc_i(28, 2, 3'b101, 3, OPI));
    put(18, enc_i(32'h41C, 2, 3'b101, 4, OPI));
    put(19, enc_r(0, 2, 0, 3'b011, 5));
    put(20, enc_s(12, 1, 0));
    put(21, enc_i(12, 0, 3'b010, 6, LD));
    put(22, addi(0, 0, 7));
    put(23, 32'h0000_0000);
    #1 reset = 1'b1;
    #1;
    chk_out("in_reset", 1'b0, 5'd0, 32'd0);
    chk("in_reset.pc", dut.u_cpu.pc, 32'h0);
    reset = 1'b0;
    #1;
    chk_out("addi_x1", 1'b1, 5'd1, 32'd5);
    tick;
    chk("x1_after", dut.u_cpu.rf[1], 32'd5);
    chk("pc_after_addi", dut.u_cpu.pc, 32'h4);
    chk_out("jal_x0", 1'b0, 5'd0, 32'd0);
    tick;
    chk("pc_after_jal_x0", dut.u_cpu.pc, 32'h40);
    chk_out("addi_m1", 1'b1, 5'd2, 32'hFFFF_FFFF);
    tick;
    chk_out("srli", 1'b1, 5'd3, 32'h0000_000F);
    tick;
    chk_out("srai", 1'b1, 5'd4, 32'hFFFF_FFFF);
    tick;
    chk_out("sltu", 1'b1, 5'd5, 32'd1);
    tick;
    chk_out("sw", 1'b0, 5'd0, 32'd0);
    chk("mem3_before_sw", dut.u_mem.mem[3], 32'hFFFF_FFFF);
    tick;
    chk("mem3_after_sw", dut.u_mem.mem[3], 32'd5);
    chk_out("lw", 1'b1, 5'd6, 32'd5);
    tick;
    chk_out("addi_x0", 1'b0, 5'd0, 32'd0);
    tick;
    chk("x0_stays", dut.u_cpu.rf[0], 32'd0);
    chk_out("nop", 1'b0, 5'd0, 32'd0);
    chk("pc_at_nop", dut.u_cpu.pc, 32'h5C);
    tick;
    chk("pc_after_nop", dut.u_cpu.pc, 32'h60);

    // Program 2: jumps and branches
    clear_mem;
    put(0,  enc_j(32'h10, 0));
    put(4,  enc_j(8, 1));
    put(5,  addi(7, 0, 1));
    put(6,  addi(9, 0, 33));
    put(7,  enc_i(0, 9, 3'b000, 10, JLR));
    put(8,  enc_b(8, 0, 9, 3'b001));
    put(9,  addi(7, 0, 1));
    put(10, enc_b(8, 0, 9, 3'b000));
    put(11, addi(11, 0, -3));
    put(12, enc_b(8, 11, 9, 3'b110));
    put(13, addi(7, 0, 1));
    put(14, enc_b(8, 9, 11, 3'b100));
    put(15, addi(7, 0, 1));
    put(16, enc_b(8, 9, 11, 3'b101));
    #1;
    pulse_reset;
    tick;
    chk("pc_jal_to_10", dut.u_cpu.pc, 32'h10);
    chk_out("jal_x1", 1'b1, 5'd1, 32'h14);
    tick;
    chk("pc_after_jal_x1", dut.u_cpu.pc, 32'h18);
    chk_out("addi_x9", 1'b1, 5'd9, 32'h21);
    tick;
    chk_out("jalr", 1'b1, 5'd10, 32'h20);
    tick;
    chk("pc_jalr_odd", dut.u_cpu.pc, 32'h20);
    tick;
    chk("pc_bne_taken", dut.u_cpu.pc, 32'h28);
    tick;
    chk("pc_beq_not_taken", dut.u_cpu.pc, 32'h2C);
    tick;
    tick;
    chk("pc_bltu_taken", dut.u_cpu.pc, 32'h38);
    tick;
    chk("pc_blt_taken", dut.u_cpu.pc, 32'h40);
    tick;
    chk("pc_bge_not_taken", dut.u_cpu.pc, 32'h44);
    chk("x7_never_written", dut.u_cpu.rf[7], 32'd0);

    // Program 3: sum 100..1 loop, checkpoint at cycle 200, then restore
    clear_mem;
    put(0,  enc_j(32'h40, 0));
    put(3,  32'hFFFF_FFFF);
    put(16, addi(1, 0, 0));
    put(17, addi(2, 0, 100));
    put(18, enc_r(0, 2, 1, 3'b000, 1));
    put(19, addi(2, 2, -1));
    put(20, enc_b(-8, 0, 2, 3'b001));
    put(21, enc_s(12, 1, 0));
    put(22, enc_j(0, 0));
    #1;
    pulse_reset;
    run_to_finish(0, 1'b0, fin1, mism);
    chk("bench_finish_cycle", fin1, 32'd304);
    chk("bench_result", dut.u_mem.mem[3], 32'h0000_13BA);

    pulse_reset;
    dut.u_cpu.pc <= saved_pc;
    dut.u_cpu.rf <= saved_rf;
    for (int i = 0; i < 128; i++) dut.u_mem.mem[i] <= saved_mem[i];
    #1;
    run_to_finish(200, 1'b1, fin2, mism);
    chk("restore_finish_cycle", fin2, 32'd304);
    chk("restore_trace_mismatches", mism, 32'd0);
    chk("restore_result", dut.u_mem.mem[3], 32'h0000_13BA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
